// File: rtl/encoder8_3_filt.sv
// ---------------------------------------------------------------------------
// encoder8_3_filt
//
// Debounced, registered 8-to-3 priority encoder. It is the inverse of the
// team's 3-to-8 one-hot decoder. An asynchronous 8-bit request vector is
// synchronised, filtered until it has been stable for STABLE_CNT cycles,
// and then committed. The committed value is priority-encoded to the index
// of its highest set bit.
//
// Parameters:
//   STABLE_CNT  consecutive cycles the synchronised input must hold
//               unchanged before it is committed (1..65535)
//
// Ports:
//   sys_clk    in   1  system clock, rising edge
//   sys_rst    in   1  synchronous active-high reset
//   in         in   8  raw request vector, bit n = request n (async)
//   out_code   out  3  index of highest set bit of the committed input
//   out_valid  out  1  committed input is non-zero
//   out_err    out  1  committed input has more than one bit set
//   code_strb  out  1  one-cycle pulse on each commit of a non-zero input
// ---------------------------------------------------------------------------
module encoder8_3_filt #(
   parameter int unsigned STABLE_CNT = 4
) (
   input  logic       sys_clk,
   input  logic       sys_rst,
   input  logic [7:0] in,
   output logic [2:0] out_code,
   output logic       out_valid,
   output logic       out_err,
   output logic       code_strb
);

   localparam int unsigned CNT_W = $clog2(STABLE_CNT) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FILTER = 2'd1,
      LOCKED = 2'd2
   } state_t;

   state_t           state;
   logic [7:0]       s1;
   logic [7:0]       s2;
   logic [7:0]       cand;
   logic [CNT_W-1:0] cnt;

   logic [2:0]       cand_code;
   logic             cand_nonzero;
   logic             cand_multi;

   // Two-flop synchroniser. The raw input is asynchronous to sys_clk, so
   // only the second stage is allowed to feed any decision logic.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         s1 <= 8'd0;
         s2 <= 8'd0;
      end else begin
         s1 <= in;
         s2 <= s1;
      end
   end

   // Priority encode of the candidate. Scanning upward lets the highest
   // set bit win, which gives a deterministic code for multi-hot inputs.
   always_comb begin
      cand_code = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if (cand[i]) begin
            cand_code = 3'(i);
         end
      end
   end

   // Clearing the lowest set bit leaves something only when two or more
   // bits were set.
   assign cand_nonzero = (cand != 8'd0);
   assign cand_multi   = ((cand & (cand - 8'd1)) != 8'd0);

   // Debounce FSM with registered outputs. Any change at s2 reloads the
   // candidate and restarts the count from every state, so a pulse shorter
   // than STABLE_CNT cycles never reaches the outputs. IDLE and LOCKED
   // simply hold while s2 matches the candidate.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state     <= IDLE;
         cand      <= 8'd0;
         cnt       <= '0;
         out_code  <= 3'd0;
         out_valid <= 1'b0;
         out_err   <= 1'b0;
         code_strb <= 1'b0;
      end else begin
         code_strb <= 1'b0;
         if (s2 != cand) begin
            cand  <= s2;
            cnt   <= '0;
            state <= FILTER;
         end else begin
            case (state)
               FILTER: begin
                  if (cnt == CNT_LAST) begin
                     state     <= LOCKED;
                     out_code  <= cand_code;
                     out_valid <= cand_nonzero;
                     out_err   <= cand_multi;
                     code_strb <= cand_nonzero;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               IDLE, LOCKED: begin
                  state <= state;
               end
               default: begin
                  state <= IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_encoder8_3_filt.sv
// ---------------------------------------------------------------------------
// tb_encoder8_3_filt
//
// Drives two encoder instances from the same input: one with the default
// STABLE_CNT of 4 and one with STABLE_CNT of 1. A behavioural model based
// on run lengths predicts the outputs of both instances on every edge.
// ---------------------------------------------------------------------------
module tb_encoder8_3_filt;

   logic       sys_clk;
   logic       rst;
   logic [7:0] in_val;

   logic [2:0] code  [2];
   logic       valid [2];
   logic       err   [2];
   logic       strb  [2];

   int checks;
   int errors;

   // Model state for each instance.
   int         stable_cnt [2];
   logic [7:0] p1         [2];
   logic [7:0] p2         [2];
   logic [7:0] cur_val    [2];
   int         run        [2];
   bit         armed      [2];
   logic [2:0] e_code     [2];
   logic       e_valid    [2];
   logic       e_err      [2];
   logic       e_strb     [2];

   encoder8_3_filt #(.STABLE_CNT(4)) dut0 (
      .sys_clk   (sys_clk),
      .sys_rst   (rst),
      .in        (in_val),
      .out_code  (code[0]),
      .out_valid (valid[0]),
      .out_err   (err[0]),
      .code_strb (strb[0])
   );

   encoder8_3_filt #(.STABLE_CNT(1)) dut1 (
      .sys_clk   (sys_clk),
      .sys_rst   (rst),
      .in        (in_val),
      .out_code  (code[1]),
      .out_valid (valid[1]),
      .out_err   (err[1]),
      .code_strb (strb[1])
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   // Advances one rising edge and updates the model. A value seen at the
   // second sync stage starts a run; once it has stayed there for
   // stable_cnt further edges it is committed exactly once.
   task automatic tick();
      @(posedge sys_clk);
      for (int i = 0; i < 2; i++) begin
         if (rst) begin
            p1[i] = 8'd0; p2[i] = 8'd0; cur_val[i] = 8'd0;
            run[i] = 0; armed[i] = 1'b0;
            e_code[i] = 3'd0; e_valid[i] = 1'b0; e_err[i] = 1'b0; e_strb[i] = 1'b0;
         end else begin
            e_strb[i] = 1'b0;
            if (p2[i] != cur_val[i]) begin
               cur_val[i] = p2[i];
               run[i] = 0;
               armed[i] = 1'b1;
            end else if (armed[i]) begin
               run[i]++;
               if (run[i] >= stable_cnt[i]) begin
                  armed[i] = 1'b0;
                  e_code[i] = 3'd0;
                  for (int b = 0; b < 8; b++) if (cur_val[i][b]) e_code[i] = 3'(b);
                  e_valid[i] = (cur_val[i] != 8'd0);
                  e_err[i]   = ($countones(cur_val[i]) > 1);
                  e_strb[i]  = (cur_val[i] != 8'd0);
               end
            end
            p2[i] = p1[i];
            p1[i] = in_val;
         end
      end
      #1;
   endtask

   task automatic test_reset();
      int strb_edge;
      rst = 1'b1; in_val = 8'h80;
      for (int t = 0; t < 5; t++) begin
         tick();
         for (int i = 0; i < 2; i++) begin
            checks++;
            if ({code[i], valid[i], err[i], strb[i]} !== 6'd0) begin
               errors++;
               $display("[TB] FAIL reset_hold dut%0d: got code=%0d valid=%0b err=%0b strb=%0b, want all 0",
                        i, code[i], valid[i], err[i], strb[i]);
            end
         end
      end
      rst = 1'b0;
      strb_edge = 0;
      for (int t = 1; t <= 10; t++) begin
         tick();
         if (strb[0] === 1'b1 && strb_edge == 0) strb_edge = t;
         for (int i = 0; i < 2; i++) begin
            checks++;
            if ({code[i], valid[i], err[i], strb[i]} !== {e_code[i], e_valid[i], e_err[i], e_strb[i]}) begin
               errors++;
               $display("[TB] FAIL reset_release dut%0d t=%0d: got %0d/%0b/%0b/%0b want %0d/%0b/%0b/%0b",
                        i, t, code[i], valid[i], err[i], strb[i], e_code[i], e_valid[i], e_err[i], e_strb[i]);
            end
         end
      end
      checks++;
      if (strb_edge != 7 || code[0] !== 3'd7) begin
         errors++;
         $display("[TB] FAIL reset_latency: got edge=%0d code=%0d, want edge=7 code=7", strb_edge, code[0]);
      end
   endtask

   task automatic test_onehot_sweep();
      for (int n = 0; n < 8; n++) begin
         int strb_cnt;
         int strb_edge;
         logic [7:0] decoded;
         decoded = 8'd1 << n;
         in_val = decoded;
         strb_cnt = 0; strb_edge = 0;
         for (int t = 1; t <= 12; t++) begin
            tick();
            if (strb[0] === 1'b1) begin
               strb_cnt++;
               strb_edge = t;
            end
            for (int i = 0; i < 2; i++) begin
               checks++;
               if ({code[i], valid[i], err[i], strb[i]} !== {e_code[i], e_valid[i], e_err[i], e_strb[i]}) begin
                  errors++;
                  $display("[TB] FAIL onehot dut%0d n=%0d t=%0d: got %0d/%0b/%0b/%0b want %0d/%0b/%0b/%0b",
                           i, n, t, code[i], valid[i], err[i], strb[i], e_code[i], e_valid[i], e_err[i], e_strb[i]);
               end
            end
         end
         checks++;
         if (strb_cnt != 1 || strb_edge != 7 || code[0] !== 3'(n) || valid[0] !== 1'b1 || err[0] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL onehot_loopback n=%0d: got strobes=%0d edge=%0d code=%0d valid=%0b err=%0b, want 1/7/%0d/1/0",
                     n, strb_cnt, strb_edge, code[0], valid[0], err[0], n);
         end
      end
   endtask

   task automatic test_multihot();
      int strb_cnt;
      in_val = 8'h24;
      strb_cnt = 0;
      for (int t = 1; t <= 12; t++) begin
         tick();
         if (strb[0] === 1'b1) strb_cnt++;
         for (int i = 0; i < 2; i++) begin
            checks++;
            if ({code[i], valid[i], err[i], strb[i]} !== {e_code[i], e_valid[i], e_err[i], e_strb[i]}) begin
               errors++;
               $display("[TB] FAIL multihot dut%0d t=%0d: got %0d/%0b/%0b/%0b want %0d/%0b/%0b/%0b",
                        i, t, code[i], valid[i], err[i], strb[i], e_code[i], e_valid[i], e_err[i], e_strb[i]);
            end
         end
      end
      checks++;
      if (strb_cnt != 1 || code[0] !== 3'd5 || valid[0] !== 1'b1 || err[0] !== 1'b1) begin
         errors++;
         $display("[TB] FAIL multihot_result: got strobes=%0d code=%0d valid=%0b err=%0b, want 1/5/1/1",
                  strb_cnt, code[0], valid[0], err[0]);
      end
   endtask

   task automatic test_glitch();
      int strb_cnt;
      bit saw_four;
      logic [7:0] seq [3];
      int         len [3];
      seq = '{8'h01, 8'h10, 8'h01};
      len = '{12, 3, 12};
      strb_cnt = 0; saw_four = 1'b0;
      for (int s = 0; s < 3; s++) begin
         in_val = seq[s];
         for (int t = 1; t <= len[s]; t++) begin
            tick();
            if (s > 0 && strb[0] === 1'b1) begin
               strb_cnt++;
               if (code[0] !== 3'd0) saw_four = 1'b1;
            end
            if (s > 0 && code[0] === 3'd4) saw_four = 1'b1;
            for (int i = 0; i < 2; i++) begin
               checks++;
               if ({code[i], valid[i], err[i], strb[i]} !== {e_code[i], e_valid[i], e_err[i], e_strb[i]}) begin
                  errors++;
                  $display("[TB] FAIL glitch dut%0d seg=%0d t=%0d: got %0d/%0b/%0b/%0b want %0d/%0b/%0b/%0b",
                           i, s, t, code[i], valid[i], err[i], strb[i], e_code[i], e_valid[i], e_err[i], e_strb[i]);
               end
            end
         end
      end
      checks++;
      if (strb_cnt != 1 || saw_four || code[0] !== 3'd0 || valid[0] !== 1'b1) begin
         errors++;
         $display("[TB] FAIL glitch_reject: got strobes=%0d leaked=%0b code=%0d valid=%0b, want 1/0/0/1",
                  strb_cnt, saw_four, code[0], valid[0]);
      end
   endtask

   task automatic test_release();
      int strb_cnt;
      int drop_edge;
      in_val = 8'h08;
      for (int t = 1; t <= 12; t++) tick();
      in_val = 8'h00;
      strb_cnt = 0; drop_edge = 0;
      for (int t = 1; t <= 12; t++) begin
         tick();
         if (strb[0] === 1'b1) strb_cnt++;
         if (valid[0] === 1'b0 && drop_edge == 0) drop_edge = t;
         for (int i = 0; i < 2; i++) begin
            checks++;
            if ({code[i], valid[i], err[i], strb[i]} !== {e_code[i], e_valid[i], e_err[i], e_strb[i]}) begin
               errors++;
               $display("[TB] FAIL release dut%0d t=%0d: got %0d/%0b/%0b/%0b want %0d/%0b/%0b/%0b",
                        i, t, code[i], valid[i], err[i], strb[i], e_code[i], e_valid[i], e_err[i], e_strb[i]);
            end
         end
      end
      checks++;
      if (strb_cnt != 0 || drop_edge != 7 || code[0] !== 3'd0 || err[0] !== 1'b0) begin
         errors++;
         $display("[TB] FAIL release_result: got strobes=%0d drop_edge=%0d code=%0d err=%0b, want 0/7/0/0",
                  strb_cnt, drop_edge, code[0], err[0]);
      end
   endtask

   task automatic test_reset_mid_filter();
      int strb_edge;
      bit early;
      in_val = 8'h40;
      early = 1'b0;
      // Third edge loads the candidate; reset lands on the next one.
      for (int t = 1; t <= 4; t++) begin
         rst = (t == 4);
         tick();
         if (valid[0] !== 1'b0 || strb[0] !== 1'b0) early = 1'b1;
      end
      rst = 1'b0;
      strb_edge = 0;
      for (int t = 1; t <= 12; t++) begin
         tick();
         if (strb[0] === 1'b1 && strb_edge == 0) strb_edge = t;
         if (t < 7 && valid[0] !== 1'b0) early = 1'b1;
         for (int i = 0; i < 2; i++) begin
            checks++;
            if ({code[i], valid[i], err[i], strb[i]} !== {e_code[i], e_valid[i], e_err[i], e_strb[i]}) begin
               errors++;
               $display("[TB] FAIL midreset dut%0d t=%0d: got %0d/%0b/%0b/%0b want %0d/%0b/%0b/%0b",
                        i, t, code[i], valid[i], err[i], strb[i], e_code[i], e_valid[i], e_err[i], e_strb[i]);
            end
         end
      end
      checks++;
      if (early || strb_edge != 7 || code[0] !== 3'd6 || valid[0] !== 1'b1) begin
         errors++;
         $display("[TB] FAIL midreset_result: got early=%0b edge=%0d code=%0d valid=%0b, want 0/7/6/1",
                  early, strb_edge, code[0], valid[0]);
      end
   endtask

   task automatic test_random();
      for (int seg = 0; seg < 250; seg++) begin
         int hold;
         if ($urandom_range(0, 2) == 0) in_val = 8'($urandom);
         else in_val = 8'd1 << $urandom_range(0, 7);
         hold = $urandom_range(1, 9);
         for (int t = 0; t < hold; t++) begin
            rst = ($urandom_range(0, 59) == 0);
            tick();
            for (int i = 0; i < 2; i++) begin
               checks++;
               if ({code[i], valid[i], err[i], strb[i]} !== {e_code[i], e_valid[i], e_err[i], e_strb[i]}) begin
                  errors++;
                  $display("[TB] FAIL random dut%0d seg=%0d in=%02h: got %0d/%0b/%0b/%0b want %0d/%0b/%0b/%0b",
                           i, seg, in_val, code[i], valid[i], err[i], strb[i], e_code[i], e_valid[i], e_err[i], e_strb[i]);
               end
            end
         end
      end
      rst = 1'b0;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      stable_cnt[0] = 4;
      stable_cnt[1] = 1;
      rst = 1'b1;
      in_val = 8'h00;
      test_reset();
      test_onehot_sweep();
      test_multihot();
      test_glitch();
      test_release();
      test_reset_mid_filter();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/encoder8_3_filt.md
Name: encoder8_3_filt

Overview:
- Inverse of the team's 3-to-8 one-hot decoder. Takes an 8-bit one-hot input (buttons, select lines) and returns the 3-bit index.
- Registered and debounced: the input is synchronised, must hold stable for a programmable number of cycles, and is then priority-encoded.
- Sits between asynchronous board inputs and control logic. Bit n of the input maps to code n, so the decoder's output fed back through this block reproduces the original code.

Parameters:
- STABLE_CNT, 4, consecutive cycles the synchronised input must hold unchanged before it is committed. Legal range 1..65535. Counter width is clog2(STABLE_CNT)+1.

Ports:
- sys_clk  input  1  system clock; all logic on the rising edge.
- sys_rst  input  1  synchronous, active-high reset.
- in  input  8  raw input, bit n = request n. Asynchronous to sys_clk.
- out_code  output  3  committed index: highest set bit of the committed input.
- out_valid  output  1  level; 1 while the committed input is non-zero.
- out_err  output  1  level; 1 while the committed input has more than one bit set.
- code_strb  output  1  single-cycle pulse on each commit of a non-zero input.

Behaviour:
- Reset: on any edge with sys_rst=1, every register clears and FSM=IDLE. Cleared registers: sync stages s1/s2, cand, cnt, out_code=0, out_valid=0, out_err=0, code_strb=0. Reset overrides all other activity, including mid-filter; a pending candidate is discarded and nothing is committed.
- Synchroniser: s1<=in, s2<=s1. Only s2 is used downstream.
- FSM states: IDLE, FILTER, LOCKED.
  - Any state, s2!=cand: cand<=s2, cnt<=0, go to FILTER. This takes priority over every other transition.
  - FILTER, s2==cand, cnt<STABLE_CNT-1: cnt<=cnt+1.
  - FILTER, s2==cand, cnt==STABLE_CNT-1: commit, go to LOCKED.
  - IDLE/LOCKED, s2==cand: hold; cnt frozen; no commit.
- Commit (outputs registered at the same edge the FSM enters LOCKED):
  - cand==0: out_code=0, out_valid=0, out_err=0, code_strb=0.
  - Exactly one bit n set: out_code=n, out_valid=1, out_err=0, code_strb=1.
  - Two or more bits set: out_code=index of highest set bit, out_valid=1, out_err=1, code_strb=1.
- code_strb returns to 0 on the next edge unconditionally.
- Outputs hold between commits.
- Latency: input change before edge E0 appears in s1 at E1, in s2 at E2, cand at E3 (cnt=0). Commit outputs appear at edge E3+STABLE_CNT, i.e. STABLE_CNT+3 edges after E0. With default 4: 7 edges.
- Glitches: any change of s2 during FILTER restarts the count, so a pulse of fewer than STABLE_CNT cycles (as seen at s2) is never committed. A glitch that returns to the previously committed value still re-commits that value after filtering; code_strb pulses again if non-zero.
- STABLE_CNT=1: commit on the edge after cand loads, i.e. 4-edge latency.
- No latch inference: every output has an assignment on every path.

Test Plan:
- Reset: drive in=8'h80 with sys_rst=1 for 5 cycles -> out_code=0, out_valid=0, out_err=0, code_strb=0 throughout. Release -> code 7 commits 7 edges later.
- One-hot sweep (STABLE_CNT=4): in = 8'h01, 02, 04, ... 80, each held 12 cycles -> out_code=0..7, out_valid=1, out_err=0, exactly one code_strb pulse per value, 7 edges after each change. Also loop the team decoder's output into in for codes 0..7 -> out_code equals the decoder input.
- Multi-hot: in=8'h24 held -> out_code=5, out_valid=1, out_err=1, code_strb pulses once.
- Glitch rejection: committed 8'h01, then in=8'h10 for 3 cycles, then back to 8'h01 -> out_code stays 0, no 8'h10 commit; one re-commit strobe with out_code=0.
- Release: from committed 8'h08, in=8'h00 held -> 7 edges later out_valid=0, out_code=0, out_err=0, no code_strb.
- Reset mid-filter: in 00->40, assert sys_rst on the 2nd cycle of FILTER for 1 cycle, keep in=40 -> outputs stay 0 through reset. Then out_code=6, out_valid=1 commits 7 edges after release (s1/s2 refill from 0).
